// File: rtl/pipe_hazard_ctrl.sv
// Control-bundle pipeline ID->EX->MEM->WB with load-use stall, operand forwarding
// selects, taken-branch IF/ID flush and a saturating stall-cycle debug counter.
module pipe_hazard_ctrl #(
    parameter int unsigned CTRL_W      = 12,
    parameter int unsigned RA_W        = 4,
    parameter int unsigned LOAD_LAT    = 1,
    parameter int unsigned PC_REG      = 15,
    parameter int unsigned STALL_CNT_W = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              id_valid,
    input  logic [CTRL_W-1:0] id_ctrl,
    input  logic              id_rf_en,
    input  logic              id_load,
    input  logic [RA_W-1:0]   id_rd,
    input  logic [RA_W-1:0]   id_rn,
    input  logic [RA_W-1:0]   id_rm,
    input  logic              id_use_rn,
    input  logic              id_use_rm,
    input  logic              branch_taken,
    output logic              pc_le,
    output logic              ifid_le,
    output logic              ifid_flush,
    output logic [CTRL_W-1:0] ex_ctrl,
    output logic [CTRL_W-1:0] mem_ctrl,
    output logic [CTRL_W-1:0] wb_ctrl,
    output logic              ex_valid,
    output logic              mem_valid,
    output logic              wb_valid,
    output logic [1:0]        fwd_a,
    output logic [1:0]        fwd_b,
    output logic [15:0]       stall_count
);

    localparam logic [RA_W-1:0] PC_IDX = RA_W'(PC_REG);
    localparam bit              LAT2   = (LOAD_LAT == 2);

    localparam logic [1:0] SEL_RF  = 2'b00;
    localparam logic [1:0] SEL_EX  = 2'b01;
    localparam logic [1:0] SEL_MEM = 2'b10;
    localparam logic [1:0] SEL_WB  = 2'b11;

    typedef struct packed {
        logic              valid;
        logic [CTRL_W-1:0] ctrl;
        logic              rf_en;
        logic              load;
        logic [RA_W-1:0]   rd;
    } stage_t;

    // WB is the last consumer, so it does not need to remember the load flag.
    typedef struct packed {
        logic              valid;
        logic [CTRL_W-1:0] ctrl;
        logic              rf_en;
        logic [RA_W-1:0]   rd;
    } wb_stage_t;

    stage_t                 id_entry;
    stage_t                 ex_q;
    stage_t                 mem_q;
    wb_stage_t              wb_q;
    logic [STALL_CNT_W-1:0] cnt_q;

    logic rn_ex, rn_mem, rn_wb;
    logic rm_ex, rm_mem, rm_wb;
    logic ex_load_hit, mem_load_hit;
    logic stall;

    function automatic logic src_match(
        input logic            s_valid,
        input logic            s_rf_en,
        input logic [RA_W-1:0] s_rd,
        input logic [RA_W-1:0] src,
        input logic            use_src
    );
        return s_valid & s_rf_en & (s_rd == src) & use_src & (src != PC_IDX);
    endfunction

    // Youngest matching producer decides; a load that cannot deliver yet yields the RF path.
    function automatic logic [1:0] fwd_sel(
        input logic m_ex,
        input logic m_mem,
        input logic m_wb,
        input logic ex_ld,
        input logic mem_ld
    );
        logic [1:0] sel;
        sel = SEL_RF;
        if (m_ex) begin
            sel = ex_ld ? SEL_RF : SEL_EX;
        end else if (m_mem) begin
            sel = (LAT2 && mem_ld) ? SEL_RF : SEL_MEM;
        end else if (m_wb) begin
            sel = SEL_WB;
        end
        return sel;
    endfunction

    // Source-versus-stage destination compares
    always_comb begin
        rn_ex  = src_match(ex_q.valid,  ex_q.rf_en,  ex_q.rd,  id_rn, id_use_rn);
        rn_mem = src_match(mem_q.valid, mem_q.rf_en, mem_q.rd, id_rn, id_use_rn);
        rn_wb  = src_match(wb_q.valid,  wb_q.rf_en,  wb_q.rd,  id_rn, id_use_rn);
        rm_ex  = src_match(ex_q.valid,  ex_q.rf_en,  ex_q.rd,  id_rm, id_use_rm);
        rm_mem = src_match(mem_q.valid, mem_q.rf_en, mem_q.rd, id_rm, id_use_rm);
        rm_wb  = src_match(wb_q.valid,  wb_q.rf_en,  wb_q.rd,  id_rm, id_use_rm);
    end

    // Load-use hazard detection
    always_comb begin
        ex_load_hit  = (rn_ex | rm_ex) & ex_q.load;
        mem_load_hit = LAT2 & (rn_mem | rm_mem) & mem_q.load;
        stall        = id_valid & (ex_load_hit | mem_load_hit);
    end

    always_comb begin
        fwd_a = fwd_sel(rn_ex, rn_mem, rn_wb, ex_q.load, mem_q.load);
        fwd_b = fwd_sel(rm_ex, rm_mem, rm_wb, ex_q.load, mem_q.load);
    end

    assign pc_le      = ~stall;
    assign ifid_le    = ~stall;
    assign ifid_flush = branch_taken & id_valid & ~stall;

    // Invalid ID slots enter EX as all-zero so downstream ctrl reads 0.
    always_comb begin
        id_entry = '0;
        if (id_valid) begin
            id_entry.valid = 1'b1;
            id_entry.ctrl  = id_ctrl;
            id_entry.rf_en = id_rf_en;
            id_entry.load  = id_load;
            id_entry.rd    = id_rd;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ex_q  <= '0;
            mem_q <= '0;
            wb_q  <= '0;
            cnt_q <= '0;
        end else begin
            ex_q        <= stall ? '0 : id_entry;
            mem_q       <= ex_q;
            wb_q.valid  <= mem_q.valid;
            wb_q.ctrl   <= mem_q.ctrl;
            wb_q.rf_en  <= mem_q.rf_en;
            wb_q.rd     <= mem_q.rd;
            if (stall && (cnt_q != '1)) begin
                cnt_q <= cnt_q + STALL_CNT_W'(1);
            end
        end
    end

    assign ex_valid    = ex_q.valid;
    assign mem_valid   = mem_q.valid;
    assign wb_valid    = wb_q.valid;
    assign ex_ctrl     = ex_q.ctrl;
    assign mem_ctrl    = mem_q.ctrl;
    assign wb_ctrl     = wb_q.ctrl;
    assign stall_count = 16'(cnt_q);

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl: LOAD_LAT=1, LOAD_LAT=2 and a narrow-counter
// instance share one stimulus stream; WB ctrl is checked against an in-order scoreboard.
module tb_pipe_hazard_ctrl;

    localparam int unsigned CW = 12;
    localparam int unsigned AW = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic          id_valid;
    logic [CW-1:0] id_ctrl;
    logic          id_rf_en;
    logic          id_load;
    logic [AW-1:0] id_rd, id_rn, id_rm;
    logic          id_use_rn, id_use_rm;
    logic          branch_taken;

    logic          pc_le_w     [3];
    logic          ifid_le_w   [3];
    logic          flush_w     [3];
    logic [CW-1:0] ex_ctrl_w   [3];
    logic [CW-1:0] mem_ctrl_w  [3];
    logic [CW-1:0] wb_ctrl_w   [3];
    logic          ex_valid_w  [3];
    logic          mem_valid_w [3];
    logic          wb_valid_w  [3];
    logic [1:0]    fwd_a_w     [3];
    logic [1:0]    fwd_b_w     [3];
    logic [15:0]   cnt_w       [3];

    logic [CW-1:0] sb [$];
    int n_cmp = 0;
    int n_mis = 0;

    always #5 clk = ~clk;

    pipe_hazard_ctrl #(.CTRL_W(CW), .RA_W(AW), .LOAD_LAT(1), .PC_REG(15)) u_lat1 (
        .clk(clk), .reset(reset), .id_valid(id_valid), .id_ctrl(id_ctrl),
        .id_rf_en(id_rf_en), .id_load(id_load), .id_rd(id_rd), .id_rn(id_rn),
        .id_rm(id_rm), .id_use_rn(id_use_rn), .id_use_rm(id_use_rm),
        .branch_taken(branch_taken), .pc_le(pc_le_w[0]), .ifid_le(ifid_le_w[0]),
        .ifid_flush(flush_w[0]), .ex_ctrl(ex_ctrl_w[0]), .mem_ctrl(mem_ctrl_w[0]),
        .wb_ctrl(wb_ctrl_w[0]), .ex_valid(ex_valid_w[0]), .mem_valid(mem_valid_w[0]),
        .wb_valid(wb_valid_w[0]), .fwd_a(fwd_a_w[0]), .fwd_b(fwd_b_w[0]),
        .stall_count(cnt_w[0])
    );

    pipe_hazard_ctrl #(.CTRL_W(CW), .RA_W(AW), .LOAD_LAT(2), .PC_REG(15)) u_lat2 (
        .clk(clk), .reset(reset), .id_valid(id_valid), .id_ctrl(id_ctrl),
        .id_rf_en(id_rf_en), .id_load(id_load), .id_rd(id_rd), .id_rn(id_rn),
        .id_rm(id_rm), .id_use_rn(id_use_rn), .id_use_rm(id_use_rm),
        .branch_taken(branch_taken), .pc_le(pc_le_w[1]), .ifid_le(ifid_le_w[1]),
        .ifid_flush(flush_w[1]), .ex_ctrl(ex_ctrl_w[1]), .mem_ctrl(mem_ctrl_w[1]),
        .wb_ctrl(wb_ctrl_w[1]), .ex_valid(ex_valid_w[1]), .mem_valid(mem_valid_w[1]),
        .wb_valid(wb_valid_w[1]), .fwd_a(fwd_a_w[1]), .fwd_b(fwd_b_w[1]),
        .stall_count(cnt_w[1])
    );

    pipe_hazard_ctrl #(.CTRL_W(CW), .RA_W(AW), .LOAD_LAT(1), .PC_REG(15),
                       .STALL_CNT_W(4)) u_sat (
        .clk(clk), .reset(reset), .id_valid(id_valid), .id_ctrl(id_ctrl),
        .id_rf_en(id_rf_en), .id_load(id_load), .id_rd(id_rd), .id_rn(id_rn),
        .id_rm(id_rm), .id_use_rn(id_use_rn), .id_use_rm(id_use_rm),
        .branch_taken(branch_taken), .pc_le(pc_le_w[2]), .ifid_le(ifid_le_w[2]),
        .ifid_flush(flush_w[2]), .ex_ctrl(ex_ctrl_w[2]), .mem_ctrl(mem_ctrl_w[2]),
        .wb_ctrl(wb_ctrl_w[2]), .ex_valid(ex_valid_w[2]), .mem_valid(mem_valid_w[2]),
        .wb_valid(wb_valid_w[2]), .fwd_a(fwd_a_w[2]), .fwd_b(fwd_b_w[2]),
        .stall_count(cnt_w[2])
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drv(input logic v, input logic [CW-1:0] c, input logic rf, input logic ld,
                       input logic [AW-1:0] rd, input logic [AW-1:0] rn, input logic [AW-1:0] rm,
                       input logic urn, input logic urm, input logic br);
        id_valid = v; id_ctrl = c; id_rf_en = rf; id_load = ld;
        id_rd = rd; id_rn = rn; id_rm = rm;
        id_use_rn = urn; id_use_rm = urm; branch_taken = br;
    endtask

    task automatic bubble();
        drv(1'b0, '0, 1'b0, 1'b0, '0, '0, '0, 1'b0, 1'b0, 1'b0);
    endtask

    // Check combinational outputs mid-cycle, record accepted ctrl, then retire at WB.
    task automatic step(input int d, input logic exp_stall, input logic exp_flush,
                        input logic [1:0] efa, input logic [1:0] efb, input string tag);
        @(negedge clk);
        chk({tag, ".pc_le"},   pc_le_w[d],   !exp_stall);
        chk({tag, ".ifid_le"}, ifid_le_w[d], !exp_stall);
        chk({tag, ".flush"},   flush_w[d],   exp_flush);
        chk({tag, ".fwd_a"},   fwd_a_w[d],   efa);
        chk({tag, ".fwd_b"},   fwd_b_w[d],   efb);
        if (id_valid && !exp_stall) sb.push_back(id_ctrl);
        @(posedge clk);
        #1;
        if (wb_valid_w[d]) begin
            if (sb.size() == 0) chk({tag, ".sb_underflow"}, wb_valid_w[d], 1'b0);
            else chk({tag, ".wb_ctrl"}, wb_ctrl_w[d], sb.pop_front());
        end
    endtask

    task automatic drain(input int d, input int n);
        bubble();
        for (int i = 0; i < n; i++) step(d, 1'b0, 1'b0, 2'b00, 2'b00, "drain");
        chk("sb_empty", sb.size(), 0);
    endtask

    task automatic do_reset();
        bubble();
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        sb.delete();
    endtask

    initial begin
        bubble();
        reset = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int d = 0; d < 3; d++) begin
            chk("rst_on.pc_le", pc_le_w[d], 1'b1);
            chk("rst_on.cnt",   cnt_w[d],   16'h0000);
        end
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        for (int d = 0; d < 3; d++) begin
            chk("rst.valids",  {ex_valid_w[d], mem_valid_w[d], wb_valid_w[d]}, 3'b000);
            chk("rst.ex_ctrl", ex_ctrl_w[d], 12'h000);
            chk("rst.mem_ctrl", mem_ctrl_w[d], 12'h000);
            chk("rst.wb_ctrl", wb_ctrl_w[d], 12'h000);
            chk("rst.le",      {pc_le_w[d], ifid_le_w[d], flush_w[d]}, 3'b110);
            chk("rst.fwd",     {fwd_a_w[d], fwd_b_w[d]}, 4'b0000);
            chk("rst.cnt",     cnt_w[d], 16'h0000);
        end
        @(posedge clk);
        #1;

        // ADD R5,R0,R3 ; ADD R6,R5,R5
        drv(1'b1, 12'h3A5, 1'b1, 1'b0, 4'd5, 4'd0, 4'd3, 1'b1, 1'b1, 1'b0);
        step(0, 1'b0, 1'b0, 2'b00, 2'b00, "add1");
        chk("add1.ex_ctrl", ex_ctrl_w[0], 12'h3A5);
        drv(1'b1, 12'h1C6, 1'b1, 1'b0, 4'd6, 4'd5, 4'd5, 1'b1, 1'b1, 1'b0);
        step(0, 1'b0, 1'b0, 2'b01, 2'b01, "add2");
        chk("add2.mem_ctrl", mem_ctrl_w[0], 12'h3A5);
        drain(0, 4);

        // LDRB R2,[R1,R0] ; ADD R4,R2,R1 with one bubble
        drv(1'b1, 12'h8F2, 1'b1, 1'b1, 4'd2, 4'd1, 4'd0, 1'b1, 1'b1, 1'b0);
        step(0, 1'b0, 1'b0, 2'b00, 2'b00, "ldrb");
        drv(1'b1, 12'h244, 1'b1, 1'b0, 4'd4, 4'd2, 4'd1, 1'b1, 1'b1, 1'b0);
        step(0, 1'b1, 1'b0, 2'b00, 2'b00, "use.stall");
        chk("use.bubble_valid", ex_valid_w[0], 1'b0);
        chk("use.bubble_ctrl",  ex_ctrl_w[0],  12'h000);
        step(0, 1'b0, 1'b0, 2'b10, 2'b00, "use.go");
        chk("use.cnt", cnt_w[0], 16'd1);
        chk("use.ex_ctrl", ex_ctrl_w[0], 12'h244);
        drain(0, 4);

        // Taken branch alone, then a branch stuck behind a load-use stall
        drv(1'b1, 12'h60B, 1'b0, 1'b0, 4'd0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b1);
        step(0, 1'b0, 1'b1, 2'b00, 2'b00, "bne");
        bubble();
        step(0, 1'b0, 1'b0, 2'b00, 2'b00, "bne.after");
        drv(1'b1, 12'hA17, 1'b1, 1'b1, 4'd7, 4'd8, 4'd0, 1'b1, 1'b0, 1'b0);
        step(0, 1'b0, 1'b0, 2'b00, 2'b00, "ldr_r7");
        drv(1'b1, 12'h5F0, 1'b0, 1'b0, 4'd0, 4'd7, 4'd0, 1'b1, 1'b0, 1'b1);
        step(0, 1'b1, 1'b0, 2'b00, 2'b00, "br.stall");
        step(0, 1'b0, 1'b1, 2'b10, 2'b00, "br.go");
        chk("br.cnt", cnt_w[0], 16'd2);
        drain(0, 4);

        // R15 as destination of a load and as both sources
        drv(1'b1, 12'hC0F, 1'b1, 1'b1, 4'd15, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0);
        step(0, 1'b0, 1'b0, 2'b00, 2'b00, "pc_wr");
        drv(1'b1, 12'h0FF, 1'b1, 1'b0, 4'd6, 4'd15, 4'd15, 1'b1, 1'b1, 1'b0);
        step(0, 1'b0, 1'b0, 2'b00, 2'b00, "pc_rd1");
        step(0, 1'b0, 1'b0, 2'b00, 2'b00, "pc_rd2");
        drain(0, 4);
        chk("pc.cnt", cnt_w[0], 16'd2);

        // LOAD_LAT = 2: two bubbles, then WB forward
        do_reset();
        chk("l2.cnt0", cnt_w[1], 16'd0);
        drv(1'b1, 12'h8F2, 1'b1, 1'b1, 4'd2, 4'd1, 4'd0, 1'b1, 1'b1, 1'b0);
        step(1, 1'b0, 1'b0, 2'b00, 2'b00, "l2.ldrb");
        drv(1'b1, 12'h244, 1'b1, 1'b0, 4'd4, 4'd2, 4'd1, 1'b1, 1'b1, 1'b0);
        step(1, 1'b1, 1'b0, 2'b00, 2'b00, "l2.s1");
        chk("l2.bubble1", ex_valid_w[1], 1'b0);
        step(1, 1'b1, 1'b0, 2'b00, 2'b00, "l2.s2");
        chk("l2.bubble2", ex_valid_w[1], 1'b0);
        step(1, 1'b0, 1'b0, 2'b11, 2'b00, "l2.go");
        chk("l2.cnt", cnt_w[1], 16'd2);
        drain(1, 4);

        // Narrow counter: LDR R2,[R2] held in ID stalls every other cycle
        do_reset();
        drv(1'b1, 12'h321, 1'b1, 1'b1, 4'd2, 4'd2, 4'd0, 1'b1, 1'b0, 1'b0);
        for (int k = 0; k < 20; k++) begin
            step(2, 1'b0, 1'b0, (k == 0) ? 2'b00 : 2'b10, 2'b00, "sat.acc");
            step(2, 1'b1, 1'b0, 2'b00, 2'b00, "sat.stl");
            if (k == 14) chk("sat.cnt15", cnt_w[2], 16'h000F);
        end
        chk("sat.cnt_hold", cnt_w[2], 16'h000F);

        // Reset mid-stall releases the stall without a clock edge
        step(2, 1'b0, 1'b0, 2'b10, 2'b00, "sat.acc2");
        #1;
        chk("midrst.pre_pc_le", pc_le_w[2], 1'b0);
        reset = 1'b1;
        #1;
        chk("midrst.pc_le",   pc_le_w[2],   1'b1);
        chk("midrst.ifid_le", ifid_le_w[2], 1'b1);
        chk("midrst.ex_valid", ex_valid_w[2], 1'b0);
        chk("midrst.cnt",     cnt_w[2],     16'h0000);
        chk("midrst.cnt_lat1", cnt_w[0],    16'h0000);
        sb.delete();
        @(negedge clk);
        reset = 1'b0;
        bubble();
        @(posedge clk);
        #1;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
